ov7670_pxl_gen: RTL and testbench

//  OV7670 camera-side pixel stream transmitter: drives pclk/vsync/href/d[7:0] like the sensor
//  in its RGB565 or YUV422 output modes, carrying synthetic patterns. Loops back into ov7670_capture
//  to test capture and frame_buffer without a sensor. Runs on the 50 MHz system clock.

---
 rtl/ov7670_pxl_gen_pkg.sv | 40 ++++
 rtl/ov7670_pxl_gen_if.sv | 27 ++
 rtl/ov7670_pxl_gen_pattern.sv | 28 ++
 rtl/ov7670_pxl_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ov7670_pxl_gen.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_pxl_gen_pkg.sv
// ov7670_pxl_gen_pkg
//  Shared definitions for the OV7670 synthetic pixel stream generator:
//  FSM state encoding, the eight RGB565 colour-bar constants and a lookup
//  helper that maps a bar index to its colour.
package ov7670_pxl_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    // Colour bars, left to right, RGB565
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ov7670_pxl_gen_if.sv
// ov7670_pxl_gen_if
//  Camera-side bus of the pixel generator.
//  Control : en, rgbmode, testmode        (into the generator)
//  Stream  : pclk, vsync, href, data[7:0] (out of the generator)
//  Status  : frame_done, busy             (out of the generator)
//  master = the generator (sensor side), slave = the consumer / controller.
interface ov7670_pxl_gen_if;
    logic       en;
    logic       rgbmode;
    logic       testmode;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;
    logic       busy;

    modport master (
        input  en, rgbmode, testmode,
        output pclk, vsync, href, data, frame_done, busy
    );

    modport slave (
        output en, rgbmode, testmode,
        input  pclk, vsync, href, data, frame_done, busy
    );
endinterface

// File: rtl/ov7670_pxl_gen_pattern.sv
// ov7670_pxl_gen_pattern
//  Combinational pixel source: produces the RGB565 value of one pixel.
//  Ports:
//   i_col       in  5   column, low bits (ramp red)
//   i_row       in  6   row, low bits (ramp green)
//   i_frame_cnt in  5   frame counter, low bits (ramp blue)
//   i_testmode  in  1   0: colour bars, 1: ramp
//   i_bar_idx   in  3   colour bar index, tracked by a counter in the top
//   o_rgb       out 16  pixel {r5,g6,b5}
module ov7670_pxl_gen_pattern
    import ov7670_pxl_gen_pkg::*;
(
    input  logic [4:0]  i_col,
    input  logic [5:0]  i_row,
    input  logic [4:0]  i_frame_cnt,
    input  logic        i_testmode,
    input  logic [2:0]  i_bar_idx,
    output logic [15:0] o_rgb
);

    always_comb begin
        o_rgb = bar_color(i_bar_idx);
        if (i_testmode) begin
            o_rgb = {i_col, i_row, i_frame_cnt};
        end
    end

endmodule

// File: rtl/ov7670_pxl_gen.sv
// ov7670_pxl_gen
//  OV7670-style pixel stream transmitter with synthetic content (colour bars
//  or ramp) in RGB565 or YUV422 byte order, for looping into a capture block.
//  Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   cam  ov7670_pxl_gen_if.master: en/rgbmode/testmode in;
//        pclk/vsync/href/data/frame_done/busy out
//  Optional build macro: PXLGEN_FRAME_STAMP_EN -- pixel (0,0) carries the
//  16-bit frame counter (high byte first) instead of the pattern.
//  The vsync/vback/vfront line counts are expected to be >= 1.
//  All stream outputs are registered and change only on the tick (the clk
//  edge where pclk falls), so a consumer samples them on pclk rising.
module ov7670_pxl_gen
    import ov7670_pxl_gen_pkg::*;
#(
    parameter int c_img_cols     = 120,
    parameter int c_img_rows     = 90,
    parameter int c_hblank       = 16,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 2,
    parameter int c_vfront_lines = 2,
    parameter int c_pclk_div     = 2
)
(
    input  logic clk,
    input  logic rst,
    ov7670_pxl_gen_if.master cam
);

    localparam int L     = 2 * c_img_cols + c_hblank;
    localparam int DW    = $clog2(c_pclk_div);
    localparam int HW    = $clog2(L);
    localparam int VW    = $clog2(c_img_rows + c_vsync_lines + c_vback_lines + c_vfront_lines + 1);
    localparam int BAR_W = c_img_cols / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    localparam logic [DW-1:0] DIV_LAST    = DW'(c_pclk_div - 1);
    localparam logic [DW-1:0] DIV_HALF    = DW'(c_pclk_div / 2);
    localparam logic [HW-1:0] H_LAST      = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT       = HW'(2 * c_img_cols);
    localparam logic [VW-1:0] VSYNC_LAST  = VW'(c_vsync_lines - 1);
    localparam logic [VW-1:0] VBACK_LAST  = VW'(c_vback_lines - 1);
    localparam logic [VW-1:0] ROW_LAST    = VW'(c_img_rows - 1);
    localparam logic [VW-1:0] VFRONT_LAST = VW'(c_vfront_lines - 1);
    localparam logic [BW-1:0] BAR_LAST    = BW'(BAR_W - 1);

    // pclk divider
    logic [DW-1:0] r_div_reg, w_div_next;
    logic          r_pclk_reg;
    logic          w_tick;

    assign w_tick     = (r_div_reg == DIV_LAST);
    assign w_div_next = w_tick ? '0 : r_div_reg + DW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_reg  <= '0;
            r_pclk_reg <= 1'b0;
        end else begin
            r_div_reg  <= w_div_next;
            r_pclk_reg <= (w_div_next >= DIV_HALF);
        end
    end

    // Frame FSM and position counters. hcnt counts ticks inside a line in
    // every non-idle state; vcnt counts lines inside the current phase
    // (in ACTIVE it is the row number).
    state_t        r_state_reg, w_state_next;
    logic [HW-1:0] r_hcnt_reg, w_hcnt_next;
    logic [VW-1:0] r_vcnt_reg, w_vcnt_next;
    logic          w_line_end;
    logic          w_start;
    logic          w_frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg <= ST_IDLE;
        end else if (w_tick) begin
            r_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_hcnt_next  = r_hcnt_reg;
        w_vcnt_next  = r_vcnt_reg;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        w_line_end   = (r_hcnt_reg == H_LAST);

        if (r_state_reg != ST_IDLE) begin
            w_hcnt_next = w_line_end ? '0 : r_hcnt_reg + HW'(1);
        end

        unique case (r_state_reg)
            ST_IDLE: begin
                if (cam.en) begin
                    w_state_next = ST_VSYNC;
                    w_hcnt_next  = '0;
                    w_vcnt_next  = '0;
                    w_start      = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (w_line_end) begin
                    if (r_vcnt_reg == VSYNC_LAST) begin
                        w_state_next = ST_VBACK;
                        w_vcnt_next  = '0;
                    end else begin
                        w_vcnt_next = r_vcnt_reg + VW'(1);
                    end
                end
            end
            ST_VBACK: begin
                if (w_line_end) begin
                    if (r_vcnt_reg == VBACK_LAST) begin
                        w_state_next = ST_ACTIVE;
                        w_vcnt_next  = '0;
                    end else begin
                        w_vcnt_next = r_vcnt_reg + VW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_line_end) begin
                    if (r_vcnt_reg == ROW_LAST) begin
                        w_state_next = ST_VFRONT;
                        w_vcnt_next  = '0;
                    end else begin
                        w_vcnt_next = r_vcnt_reg + VW'(1);
                    end
                end
            end
            ST_VFRONT: begin
                if (w_line_end && (r_vcnt_reg == VFRONT_LAST)) begin
                    w_frame_end = 1'b1;
                    w_vcnt_next = '0;
                    // en is only sampled here, so dropping it mid-frame
                    // always lets the current frame finish.
                    if (cam.en) begin
                        w_state_next = ST_VSYNC;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_line_end) begin
                    w_vcnt_next = r_vcnt_reg + VW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hcnt_next  = '0;
                w_vcnt_next  = '0;
            end
        endcase
    end

    // Colour-bar position: a per-pixel counter replaces c/(cols/8).
    // Bar registers describe the pixel shown in the coming pclk period.
    logic [BW-1:0] r_bar_cnt_reg, w_bar_cnt_next;
    logic [2:0]    r_bar_idx_reg, w_bar_idx_next;

    always_comb begin
        w_bar_cnt_next = r_bar_cnt_reg;
        w_bar_idx_next = r_bar_idx_reg;
        if (w_hcnt_next == '0) begin
            w_bar_cnt_next = '0;
            w_bar_idx_next = '0;
        end else if (!w_hcnt_next[0]) begin
            // even byte index = first byte of a new pixel
            if (r_bar_cnt_reg == BAR_LAST) begin
                w_bar_cnt_next = '0;
                w_bar_idx_next = r_bar_idx_reg + 3'd1;
            end else begin
                w_bar_cnt_next = r_bar_cnt_reg + BW'(1);
            end
        end
    end

    // Mode latches, frame counter and registered outputs
    logic        r_rgbmode_reg, r_testmode_reg;
    logic [15:0] r_frame_cnt_reg;
    logic        r_vsync_reg, r_href_reg, r_busy_reg, r_frame_done_reg;
    logic [7:0]  r_data_reg;
    logic        w_href_next;
    logic [7:0]  w_data_next;
    logic [15:0] w_rgb;

    ov7670_pxl_gen_pattern u_pattern (
        .i_col       (5'(w_hcnt_next >> 1)),
        .i_row       (6'(w_vcnt_next)),
        .i_frame_cnt (r_frame_cnt_reg[4:0]),
        .i_testmode  (r_testmode_reg),
        .i_bar_idx   (w_bar_idx_next),
        .o_rgb       (w_rgb)
    );

    always_comb begin
        w_href_next = (w_state_next == ST_ACTIVE) && (w_hcnt_next < H_ACT);
        w_data_next = 8'h00;
        if (w_href_next) begin
            if (!w_hcnt_next[0]) begin
                w_data_next = r_rgbmode_reg ? w_rgb[15:8] : {w_rgb[10:5], 2'b00};
            end else begin
                w_data_next = r_rgbmode_reg ? w_rgb[7:0] : 8'h80;
            end
`ifdef PXLGEN_FRAME_STAMP_EN
            if ((w_vcnt_next == '0) && ((w_hcnt_next >> 1) == '0)) begin
                w_data_next = w_hcnt_next[0] ? r_frame_cnt_reg[7:0] : r_frame_cnt_reg[15:8];
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt_reg       <= '0;
            r_vcnt_reg       <= '0;
            r_bar_cnt_reg    <= '0;
            r_bar_idx_reg    <= '0;
            r_rgbmode_reg    <= 1'b0;
            r_testmode_reg   <= 1'b0;
            r_frame_cnt_reg  <= '0;
            r_vsync_reg      <= 1'b0;
            r_href_reg       <= 1'b0;
            r_data_reg       <= 8'h00;
            r_busy_reg       <= 1'b0;
            r_frame_done_reg <= 1'b0;
        end else begin
            r_frame_done_reg <= 1'b0;
            if (w_tick) begin
                r_hcnt_reg       <= w_hcnt_next;
                r_vcnt_reg       <= w_vcnt_next;
                r_bar_cnt_reg    <= w_bar_cnt_next;
                r_bar_idx_reg    <= w_bar_idx_next;
                r_vsync_reg      <= (w_state_next == ST_VSYNC);
                r_href_reg       <= w_href_next;
                r_data_reg       <= w_data_next;
                r_busy_reg       <= (w_state_next != ST_IDLE);
                r_frame_done_reg <= w_frame_end;
                if (w_frame_end) begin
                    r_frame_cnt_reg <= r_frame_cnt_reg + 16'd1;
                end
                // modes are frozen for the whole frame
                if (w_start) begin
                    r_rgbmode_reg  <= cam.rgbmode;
                    r_testmode_reg <= cam.testmode;
                end
            end
        end
    end

    assign cam.pclk       = r_pclk_reg;
    assign cam.vsync      = r_vsync_reg;
    assign cam.href       = r_href_reg;
    assign cam.data       = r_data_reg;
    assign cam.frame_done = r_frame_done_reg;
    assign cam.busy       = r_busy_reg;

endmodule

// File: tb/tb_ov7670_pxl_gen.sv
// tb_ov7670_pxl_gen
//  Directed bench for ov7670_pxl_gen with a small geometry
//  (8x2 pixels, hblank 4, one line each of vsync/vback/vfront, pclk = clk/2).
//  Expected bytes are queued when a frame is requested and popped on each
//  pclk rising edge with href high. Line/frame timing is tracked alongside.
`timescale 1ns/1ps
module tb_ov7670_pxl_gen;

    localparam int COLS = 8;
    localparam int ROWS = 2;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ov7670_pxl_gen_if cam ();

    ov7670_pxl_gen #(
        .c_img_cols     (COLS),
        .c_img_rows     (ROWS),
        .c_hblank       (4),
        .c_vsync_lines  (1),
        .c_vback_lines  (1),
        .c_vfront_lines (1),
        .c_pclk_div     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cam (cam)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] fcnt_model = 16'd0;
    bit          mon_on = 1'b1;
    int          fd_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input bit test, input int c, input int r,
                                              input logic [15:0] f);
        logic [15:0] p;
        logic [4:0]  c5;
        logic [5:0]  r6;
        c5 = 5'(c);
        r6 = 6'(r);
        if (test) p = {c5, r6, f[4:0]};
        else      p = BARS[c / (COLS / 8)];
        return p;
    endfunction

    task automatic push_frame(input bit rgb, input bit test);
        logic [15:0] p;
        logic [7:0]  b0, b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                p  = model_pix(test, c, r, fcnt_model);
                b0 = rgb ? p[15:8] : {p[10:5], 2'b00};
                b1 = rgb ? p[7:0]  : 8'h80;
`ifdef PXLGEN_FRAME_STAMP_EN
                if (r == 0 && c == 0) begin
                    b0 = fcnt_model[15:8];
                    b1 = fcnt_model[7:0];
                end
`endif
                exp_q.push_back(b0);
                exp_q.push_back(b1);
            end
        end
        fcnt_model = fcnt_model + 16'd1;
    endtask

    task automatic wait_fd(input int target, input int budget);
        int n;
        n = 0;
        while (fd_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fd_wait", fd_count, target);
    endtask

    task automatic wait_busy(input logic v, input int budget);
        int n;
        n = 0;
        while (cam.busy !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_wait", cam.busy, v);
    endtask

    // Monitor: sampled on the falling clk edge, away from output updates.
    int   cyc = 0;
    int   t0 = -1;
    int   hrun = 0, lrun = 0, vrun = 0;
    bit   seen_line = 1'b0;
    logic prev_pclk = 1'b0, prev_fd = 1'b0, prev_vs_clk = 1'b0;
    logic prev_vs_p = 1'b0, prev_href = 1'b0;
    logic [7:0] e;

    always @(negedge clk) begin
        cyc++;
        if (cam.frame_done === 1'b1 && prev_fd !== 1'b1) begin
            fd_count++;
            $display("frame_done #%0d at cycle %0d", fd_count, cyc);
        end
        if (!mon_on) begin
            hrun = 0; lrun = 0; vrun = 0; seen_line = 1'b0; t0 = -1;
            prev_vs_p = cam.vsync;
            prev_href = cam.href;
        end else begin
            if (prev_fd === 1'b1) check("fd_width", cam.frame_done, 1'b0);
            if (cam.frame_done === 1'b1 && prev_fd !== 1'b1 && t0 >= 0)
                check("fd_time", cyc - t0, 200);
            if (cam.vsync === 1'b1 && prev_vs_clk !== 1'b1) t0 = cyc;
            if (cam.pclk === 1'b1 && prev_pclk !== 1'b1) begin
                if (cam.vsync === 1'b1) begin
                    if (prev_vs_p !== 1'b1) seen_line = 1'b0;
                    vrun++;
                end else if (prev_vs_p === 1'b1) begin
                    check("vsync_len", vrun, 20);
                    vrun = 0;
                end
                if (cam.href === 1'b1) begin
                    if (prev_href !== 1'b1 && seen_line) check("hblank_len", lrun, 4);
                    hrun++;
                    lrun = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL sb_underflow observed=%0h expected=none", cam.data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("byte data=%02h expected=%02h", cam.data, e);
                        check("sb_byte", cam.data, e);
                    end
                end else begin
                    if (prev_href === 1'b1) begin
                        check("href_len", hrun, 16);
                        hrun = 0;
                        seen_line = 1'b1;
                    end
                    lrun++;
                    check("idle_data", cam.data, 8'h00);
                end
                prev_vs_p = cam.vsync;
                prev_href = cam.href;
            end
        end
        prev_pclk   = cam.pclk;
        prev_fd     = cam.frame_done;
        prev_vs_clk = cam.vsync;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cam.en       = 1'b0;
        cam.rgbmode  = 1'b1;
        cam.testmode = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pclk",  cam.pclk, 1'b0);
        check("rst_vsync", cam.vsync, 1'b0);
        check("rst_href",  cam.href, 1'b0);
        check("rst_data",  cam.data, 8'h00);
        check("rst_busy",  cam.busy, 1'b0);
        check("rst_fd",    cam.frame_done, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Frame 0: bars RGB565; modes changed during its vsync must not apply yet
        cam.en = 1'b1;
        push_frame(1'b1, 1'b0);
        wait_busy(1'b1, 10);
        repeat (10) @(negedge clk);
        cam.rgbmode  = 1'b0;
        cam.testmode = 1'b1;
        push_frame(1'b0, 1'b1);          // frame 1: ramp YUV
        wait_fd(1, 400);

        repeat (10) @(negedge clk);
        cam.rgbmode  = 1'b1;
        cam.testmode = 1'b1;
        push_frame(1'b1, 1'b1);          // frame 2: ramp RGB565
        wait_fd(2, 400);

        // Frame 2 in progress: drop en and flip rgbmode; frame still completes unchanged
        repeat (10) @(negedge clk);
        cam.en      = 1'b0;
        cam.rgbmode = 1'b0;
        wait_fd(3, 400);
        @(negedge clk);
        check("idle_busy", cam.busy, 1'b0);
        repeat (300) @(negedge clk);
        check("idle_stay_busy", cam.busy, 1'b0);
        check("idle_fd_count", fd_count, 3);
        check("sb_drain1", exp_q.size(), 0);

        // Asynchronous reset in the middle of an active line
        mon_on       = 1'b0;
        cam.rgbmode  = 1'b1;
        cam.testmode = 1'b0;
        cam.en       = 1'b1;
        begin
            int n;
            n = 0;
            while (cam.href !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("href_wait", cam.href, 1'b1);
        end
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        cam.en = 1'b0;
        #1;
        check("arst_vsync", cam.vsync, 1'b0);
        check("arst_href",  cam.href, 1'b0);
        check("arst_data",  cam.data, 8'h00);
        check("arst_busy",  cam.busy, 1'b0);
        @(negedge clk);
        check("arst_pclk_hold", cam.pclk, 1'b0);
        rst = 1'b0;
        #1;
        check("pclk_restart_low", cam.pclk, 1'b0);
        @(posedge clk);
        #1;
        check("pclk_first_rise", cam.pclk, 1'b1);

        // After reset the frame counter restarts: ramp blue and stamp are 0 again
        exp_q.delete();
        fcnt_model = 16'd0;
        @(negedge clk);
        mon_on       = 1'b1;
        cam.rgbmode  = 1'b1;
        cam.testmode = 1'b1;
        cam.en       = 1'b1;
        push_frame(1'b1, 1'b1);
        wait_busy(1'b1, 10);
        repeat (10) @(negedge clk);
        cam.en = 1'b0;
        wait_fd(4, 400);
        repeat (20) @(negedge clk);
        check("sb_drain2", exp_q.size(), 0);
        check("final_busy", cam.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
